// File: rtl/exception_ctrl.sv
// exception_ctrl: synchronises external interrupt lines, resolves the
// highest-priority exception on the memory-stage instruction, commits it to
// CP0 as a one-cycle pulse, flushes the pipeline for FLUSH_CYCLES cycles and
// then hands a redirect PC to fetch over a valid/ready handshake.
// Optional feature macro: EXC_TRAP_EN (trap condition participates as Tr 0x0D).
module exception_ctrl #(
    parameter int unsigned NUM_HW_INT   = 6,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    output logic [NUM_HW_INT-1:0] hw_int_sync_o,
    input  logic                  mem_valid_i,
    input  logic [31:0]           mem_pc_i,
    input  logic                  mem_in_ds_i,
    input  logic [7:0]            mem_except_i,
    input  logic                  mem_adel_i,
    input  logic                  mem_ades_i,
    input  logic                  mem_trap_i,
    input  logic [31:0]           mem_badvaddr_i,
    input  logic [31:0]           cp0_status_i,
    input  logic [31:0]           cp0_cause_i,
    input  logic [31:0]           cp0_epc_i,
    output logic                  exc_commit_o,
    output logic [4:0]            exc_code_o,
    output logic [31:0]           exc_epc_o,
    output logic                  exc_bd_o,
    output logic [31:0]           exc_badvaddr_o,
    output logic                  exc_is_eret_o,
    output logic                  flush_o,
    output logic                  redirect_valid_o,
    input  logic                  redirect_ready_i,
    output logic [31:0]           redirect_pc_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(FLUSH_CYCLES - 1);

    state_t                state_r;
    logic [3:0]            cnt_r;
    logic [NUM_HW_INT-1:0] sync_r [SYNC_STAGES];

    logic        int_req_s;
    logic        trap_s;
    logic        exc_hit_s;
    logic [4:0]  exc_code_s;
    logic        exc_eret_s;
    logic [31:0] exc_badv_s;
    logic [31:0] exc_epc_s;
    logic [31:0] redir_pc_s;
    logic        unused_s;

    // Only the IP/IM byte, EXL, IE and selected except bits are architecturally used.
    assign unused_s = ^{mem_trap_i, mem_except_i[1:0], cp0_status_i[31:16],
                        cp0_status_i[7:2], cp0_cause_i[31:16], cp0_cause_i[7:0]};

`ifdef EXC_TRAP_EN
    assign trap_s = mem_trap_i;
`else
    assign trap_s = 1'b0;
`endif

    // An interrupt is taken only if unmasked, not already in exception level, and globally enabled.
    assign int_req_s  = (|(cp0_cause_i[15:8] & cp0_status_i[15:8])) & ~cp0_status_i[1] & cp0_status_i[0];
    assign exc_epc_s  = mem_in_ds_i ? (mem_pc_i - 32'd4) : mem_pc_i;
    assign redir_pc_s = exc_eret_s ? cp0_epc_i : EXC_VECTOR;
    assign hw_int_sync_o = sync_r[SYNC_STAGES-1];

    // Multi-flop synchroniser chain for the asynchronous interrupt lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {NUM_HW_INT{1'b0}};
            end
        end else begin
            sync_r[0] <= hw_int_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Fixed-priority resolution of the memory-stage exception sources.
    always_comb begin
        exc_hit_s  = 1'b1;
        exc_code_s = 5'h00;
        exc_eret_s = 1'b0;
        exc_badv_s = 32'h0000_0000;
        if (!mem_valid_i) begin
            exc_hit_s = 1'b0;
        end else if (int_req_s) begin
            exc_code_s = 5'h00;
        end else if (mem_except_i[7]) begin
            exc_code_s = 5'h04;
            exc_badv_s = mem_pc_i;
        end else if (mem_adel_i) begin
            exc_code_s = 5'h04;
            exc_badv_s = mem_badvaddr_i;
        end else if (mem_ades_i) begin
            exc_code_s = 5'h05;
            exc_badv_s = mem_badvaddr_i;
        end else if (mem_except_i[6]) begin
            exc_code_s = 5'h08;
        end else if (mem_except_i[5]) begin
            exc_code_s = 5'h09;
        end else if (mem_except_i[4]) begin
            exc_eret_s = 1'b1;
        end else if (mem_except_i[3]) begin
            exc_code_s = 5'h0A;
        end else if (mem_except_i[2]) begin
            exc_code_s = 5'h0C;
        end else if (trap_s) begin
            exc_code_s = 5'h0D;
        end else begin
            exc_hit_s = 1'b0;
        end
    end

    // Control FSM: capture on detection, flush for a fixed time, then hold the redirect until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            cnt_r            <= 4'd0;
            exc_commit_o     <= 1'b0;
            exc_code_o       <= 5'h00;
            exc_epc_o        <= 32'h0000_0000;
            exc_bd_o         <= 1'b0;
            exc_badvaddr_o   <= 32'h0000_0000;
            exc_is_eret_o    <= 1'b0;
            flush_o          <= 1'b0;
            busy_o           <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= 32'h0000_0000;
        end else begin
            exc_commit_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (exc_hit_s) begin
                        state_r        <= ST_FLUSH;
                        cnt_r          <= 4'd0;
                        exc_commit_o   <= 1'b1;
                        exc_code_o     <= exc_code_s;
                        exc_epc_o      <= exc_epc_s;
                        exc_bd_o       <= mem_in_ds_i;
                        exc_badvaddr_o <= exc_badv_s;
                        exc_is_eret_o  <= exc_eret_s;
                        redirect_pc_o  <= redir_pc_s;
                        flush_o        <= 1'b1;
                        busy_o         <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r          <= ST_REDIRECT;
                        cnt_r            <= 4'd0;
                        redirect_valid_o <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_r          <= ST_IDLE;
                        redirect_valid_o <= 1'b0;
                        flush_o          <= 1'b0;
                        busy_o           <= 1'b0;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    cnt_r            <= 4'd0;
                    redirect_valid_o <= 1'b0;
                    flush_o          <= 1'b0;
                    busy_o           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_exception_ctrl;

    localparam int          NH  = 6;
    localparam int          SS  = 2;
    localparam int          FC  = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NH-1:0] hw_int_i = '0;
    logic [NH-1:0] hw_int_sync_o;
    logic          mem_valid_i = 1'b0;
    logic [31:0]   mem_pc_i = 32'h0;
    logic          mem_in_ds_i = 1'b0;
    logic [7:0]    mem_except_i = 8'h0;
    logic          mem_adel_i = 1'b0, mem_ades_i = 1'b0, mem_trap_i = 1'b0;
    logic [31:0]   mem_badvaddr_i = 32'h0;
    logic [31:0]   cp0_status_i = 32'h0, cp0_cause_i = 32'h0, cp0_epc_i = 32'h0;
    logic          exc_commit_o, exc_bd_o, exc_is_eret_o, flush_o, busy_o;
    logic [4:0]    exc_code_o;
    logic [31:0]   exc_epc_o, exc_badvaddr_o, redirect_pc_o;
    logic          redirect_valid_o;
    logic          redirect_ready_i = 1'b0;

    exception_ctrl #(.NUM_HW_INT(NH), .SYNC_STAGES(SS), .FLUSH_CYCLES(FC), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst), .hw_int_i(hw_int_i), .hw_int_sync_o(hw_int_sync_o),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_ds_i(mem_in_ds_i),
        .mem_except_i(mem_except_i), .mem_adel_i(mem_adel_i), .mem_ades_i(mem_ades_i),
        .mem_trap_i(mem_trap_i), .mem_badvaddr_i(mem_badvaddr_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .exc_commit_o(exc_commit_o), .exc_code_o(exc_code_o), .exc_epc_o(exc_epc_o),
        .exc_bd_o(exc_bd_o), .exc_badvaddr_o(exc_badvaddr_o), .exc_is_eret_o(exc_is_eret_o),
        .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_ready_i(redirect_ready_i),
        .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc;
    int          m_commit_cyc;
    bit          m_busy;
    bit          m_commit;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_badv, m_rpc;
    bit          m_bd, m_eret;
    logic [NH-1:0] m_hist [SS];
    logic [1:0]  sw_ip = 2'b00;

    function automatic bit m_valid();
        return m_busy && ((cyc - m_commit_cyc) >= FC);
    endfunction

    task automatic model_reset();
        cyc = 0; m_commit_cyc = 0; m_busy = 0; m_commit = 0;
        m_code = 5'h0; m_epc = 32'h0; m_badv = 32'h0; m_rpc = 32'h0; m_bd = 0; m_eret = 0;
        for (int i = 0; i < SS; i++) m_hist[i] = '0;
    endtask

    // Priority table walk: first true source wins.
    task automatic resolve(output bit hit, output logic [4:0] code, output logic [31:0] badv, output bit eret);
        bit          cond [10];
        logic [4:0]  codes [10];
        logic [31:0] bv [10];
        bit          intr;
        intr = ((cp0_cause_i[15:8] & cp0_status_i[15:8]) != 8'h00) && !cp0_status_i[1] && cp0_status_i[0];
        cond[0] = intr;             codes[0] = 5'h00; bv[0] = 32'h0;
        cond[1] = mem_except_i[7];  codes[1] = 5'h04; bv[1] = mem_pc_i;
        cond[2] = mem_adel_i;       codes[2] = 5'h04; bv[2] = mem_badvaddr_i;
        cond[3] = mem_ades_i;       codes[3] = 5'h05; bv[3] = mem_badvaddr_i;
        cond[4] = mem_except_i[6];  codes[4] = 5'h08; bv[4] = 32'h0;
        cond[5] = mem_except_i[5];  codes[5] = 5'h09; bv[5] = 32'h0;
        cond[6] = mem_except_i[4];  codes[6] = 5'h00; bv[6] = 32'h0;
        cond[7] = mem_except_i[3];  codes[7] = 5'h0A; bv[7] = 32'h0;
        cond[8] = mem_except_i[2];  codes[8] = 5'h0C; bv[8] = 32'h0;
`ifdef EXC_TRAP_EN
        cond[9] = mem_trap_i;
`else
        cond[9] = 1'b0;
`endif
        codes[9] = 5'h0D; bv[9] = 32'h0;
        hit = 0; code = 5'h0; badv = 32'h0; eret = 0;
        if (mem_valid_i) begin
            for (int i = 0; i < 10; i++) begin
                if (cond[i] && !hit) begin
                    hit = 1; code = codes[i]; badv = bv[i]; eret = (i == 6);
                end
            end
        end
    endtask

    task automatic check_all();
        check_val("commit",   exc_commit_o,     m_commit);
        check_val("flush",    flush_o,          m_busy);
        check_val("busy",     busy_o,           m_busy);
        check_val("rvalid",   redirect_valid_o, m_valid());
        check_val("rpc",      redirect_pc_o,    m_rpc);
        check_val("sync",     hw_int_sync_o,    m_hist[SS-1]);
        check_val("code",     exc_code_o,       m_code);
        check_val("epc",      exc_epc_o,        m_epc);
        check_val("bd",       exc_bd_o,         m_bd);
        check_val("badvaddr", exc_badvaddr_o,   m_badv);
        check_val("is_eret",  exc_is_eret_o,    m_eret);
    endtask

    // One clock: CP0 Cause fed back from the expected synchroniser output, model advanced, outputs checked.
    task automatic step();
        bit hit, eret, hand, detect;
        logic [4:0] code;
        logic [31:0] badv;
        logic [NH-1:0] hw_now;
        cp0_cause_i = {16'h0000, m_hist[SS-1], sw_ip, 8'h00};
        resolve(hit, code, badv, eret);
        detect = !m_busy && hit;
        hand   = m_valid() && redirect_ready_i;
        hw_now = hw_int_i;
        if (detect) begin
            m_code = code; m_badv = badv; m_eret = eret; m_bd = mem_in_ds_i;
            m_epc  = mem_in_ds_i ? mem_pc_i - 32'd4 : mem_pc_i;
            m_rpc  = eret ? cp0_epc_i : VEC;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = hw_now;
        m_commit = detect;
        if (detect) begin
            m_busy = 1; m_commit_cyc = cyc;
        end else if (hand) begin
            m_busy = 0;
        end
        check_all();
    endtask

    task automatic set_idle();
        mem_valid_i = 0; mem_pc_i = 32'h0; mem_in_ds_i = 0; mem_except_i = 8'h0;
        mem_adel_i = 0; mem_ades_i = 0; mem_trap_i = 0; mem_badvaddr_i = 32'h0;
        cp0_status_i = 32'h0; cp0_epc_i = 32'h0; sw_ip = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        mem_valid_i = 0; redirect_ready_i = 1;
        while (m_busy && n < 50) begin
            step();
            n++;
        end
        check_val("drain_bound", {31'h0, m_busy}, 32'h0);
    endtask

    int cnt;

    initial begin
        model_reset();
        set_idle();
        #12;
        check_all();
        @(negedge clk);
        rst = 1;

        // Syscall, ready high: flush lasts FC+1 cycles, redirect to vector.
        mem_valid_i = 1; mem_pc_i = 32'h8000_1000; mem_except_i = 8'h40; redirect_ready_i = 1;
        step();
        check_val("sys_code", exc_code_o, 32'h08);
        check_val("sys_epc", exc_epc_o, 32'h8000_1000);
        mem_valid_i = 0;
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (flush_o) cnt++;
            if (flush_o && redirect_valid_o) check_val("sys_rpc", redirect_pc_o, VEC);
        end
        check_val("sys_flush_len", cnt, 32'd3);

        // Fetch AdEL in delay slot beats overflow.
        set_idle();
        mem_valid_i = 1; mem_pc_i = 32'h8000_2002; mem_in_ds_i = 1; mem_except_i = 8'h84;
        step();
        check_val("adel_code", exc_code_o, 32'h04);
        check_val("adel_epc", exc_epc_o, 32'h8000_1FFE);
        check_val("adel_bd", exc_bd_o, 32'h1);
        check_val("adel_bv", exc_badvaddr_o, 32'h8000_2002);
        drain();

        // Interrupt beats RI; with EXL set RI is taken instead.
        set_idle();
        cp0_status_i = 32'h0000_0401; hw_int_i = 6'h01;
        repeat (SS + 1) step();
        mem_valid_i = 1; mem_except_i = 8'h08; mem_pc_i = 32'h8000_3000;
        step();
        check_val("int_code", exc_code_o, 32'h00);
        check_val("int_commit", exc_commit_o, 32'h1);
        drain();
        cp0_status_i = 32'h0000_0403; mem_valid_i = 1;
        step();
        check_val("exl_ri_code", exc_code_o, 32'h0A);
        drain();
        hw_int_i = 6'h00;

        // ERET with ready held low; syscall while busy is ignored.
        set_idle();
        redirect_ready_i = 0;
        mem_valid_i = 1; mem_except_i = 8'h10; cp0_epc_i = 32'h8000_0040; mem_pc_i = 32'h8000_4000;
        step();
        cnt = exc_commit_o;
        check_val("eret_flag", exc_is_eret_o, 32'h1);
        mem_except_i = 8'h40; cp0_epc_i = 32'h1234_5678;
        repeat (FC) begin step(); cnt += exc_commit_o; end
        for (int i = 0; i < 5; i++) begin
            check_val("eret_valid", redirect_valid_o, 32'h1);
            check_val("eret_pc", redirect_pc_o, 32'h8000_0040);
            step();
            cnt += exc_commit_o;
        end
        mem_valid_i = 0; redirect_ready_i = 1;
        step();
        check_val("eret_commits", cnt, 32'd1);
        check_val("eret_done", busy_o, 32'h0);

        // Async reset in first FLUSH cycle, then Bp.
        set_idle();
        mem_valid_i = 1; mem_except_i = 8'h40; mem_pc_i = 32'h8000_5000;
        step();
        #2 rst = 0;
        #1;
        check_val("rst_flush", flush_o, 32'h0);
        check_val("rst_busy", busy_o, 32'h0);
        check_val("rst_code", exc_code_o, 32'h0);
        check_val("rst_epc", exc_epc_o, 32'h0);
        check_val("rst_rpc", redirect_pc_o, 32'h0);
        check_val("rst_commit", exc_commit_o, 32'h0);
        model_reset();
        set_idle();
        @(negedge clk);
        rst = 1;
        mem_valid_i = 1; mem_except_i = 8'h20; mem_pc_i = 32'h8000_6000;
        step();
        check_val("bp_code", exc_code_o, 32'h09);
        drain();

        // Trap alone.
        set_idle();
        mem_valid_i = 1; mem_trap_i = 1;
        step();
`ifdef EXC_TRAP_EN
        check_val("trap_code", exc_code_o, 32'h0D);
        check_val("trap_commit", exc_commit_o, 32'h1);
`else
        check_val("trap_commit", exc_commit_o, 32'h0);
        check_val("trap_flush", flush_o, 32'h0);
`endif
        drain();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            mem_valid_i = ($urandom_range(0, 9) < 7);
            mem_pc_i = $urandom;
            mem_in_ds_i = $urandom_range(0, 1);
            for (int b = 0; b < 8; b++) mem_except_i[b] = ($urandom_range(0, 7) == 0);
            mem_adel_i = ($urandom_range(0, 11) == 0);
            mem_ades_i = ($urandom_range(0, 11) == 0);
            mem_trap_i = ($urandom_range(0, 5) == 0);
            mem_badvaddr_i = $urandom;
            cp0_status_i = {16'h0000, 8'($urandom), 6'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom)};
            cp0_epc_i = $urandom;
            if ($urandom_range(0, 9) == 0) hw_int_i[$urandom_range(0, NH - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) sw_ip = 2'($urandom);
            redirect_ready_i = $urandom_range(0, 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Sequential exception controller for the MIPS core, between the memory stage and CP0/fetch. Synchronises a parametrised number of external hardware interrupt lines and resolves the highest-priority exception on the memory-stage instruction. It commits the exception to CP0 as a one-cycle pulse, holds a pipeline flush for a programmable number of cycles, then issues a valid/ready redirect to fetch.

## Interface
- `NUM_HW_INT`, 6: number of external interrupt lines (1..6); they map to Cause.IP[NUM_HW_INT+1:2].
- `SYNC_STAGES`, 2: flop stages per interrupt synchroniser (≥2).
- `FLUSH_CYCLES`, 2: cycles spent in FLUSH (1..15).
- `EXC_VECTOR`, 32'hBFC0_0380: redirect target for all non-ERET exceptions.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `hw_int_i` in NUM_HW_INT: asynchronous interrupt lines.
- `hw_int_sync_o` out NUM_HW_INT: synchronised lines, to CP0 Cause.IP.
- `mem_valid_i` in 1: memory-stage instruction valid.
- `mem_pc_i` in 32: its PC.
- `mem_in_ds_i` in 1: it sits in a branch delay slot.
- `mem_except_i` in 8: [7] fetch AdEL, [6] syscall, [5] break, [4] eret, [3] RI, [2] overflow; [1:0] unused.
- `mem_adel_i` / `mem_ades_i` in 1 each: data load/store address error.
- `mem_trap_i` in 1: trap condition true.
- `mem_badvaddr_i` in 32: data address.
- `cp0_status_i`, `cp0_cause_i`, `cp0_epc_i` in 32 each: current CP0 registers.
- `exc_commit_o` out 1: one-cycle commit pulse to CP0.
- `exc_code_o` out 5: ExcCode.
- `exc_epc_o` out 32: EPC.
- `exc_bd_o` out 1: Cause.BD.
- `exc_badvaddr_o` out 32: BadVAddr.
- `exc_is_eret_o` out 1: the commit is an ERET.
- `flush_o` out 1: flush all stages.
- `redirect_valid_o` out 1 / `redirect_ready_i` in 1 / `redirect_pc_o` out 32: fetch redirect handshake.
- `busy_o` out 1: state ≠ IDLE.

## Operation
- Interrupt condition is `int_req = |(Cause[15:8] & Status[15:8]) & ~Status.EXL[1] & Status.IE[0]`.
- Priority, highest first, gated by `mem_valid_i`:
  - Int 0x00
  - AdEL (except[7] or `mem_adel_i`) 0x04
  - AdES 0x05
  - Sys 0x08
  - Bp 0x09
  - ERET
  - RI 0x0A
  - Ov 0x0C
  - Tr 0x0D
- BadVAddr:
  - `mem_pc_i` when except[7] wins.
  - `mem_badvaddr_i` for data AdEL/AdES.
  - 0 otherwise.
- EPC is `mem_pc_i - 4` when `mem_in_ds_i`, else `mem_pc_i`. `exc_bd_o = mem_in_ds_i`.
- ERET: `exc_is_eret_o = 1`, `exc_code_o = 0`, `redirect_pc_o = cp0_epc_i` sampled at detection.
- All other exceptions: `redirect_pc_o = EXC_VECTOR`.
- FSM:
  - IDLE → FLUSH on any resolved exception; all `exc_*` and redirect PC are registered on that edge.
  - FLUSH counts FLUSH_CYCLES cycles, then → REDIRECT.
  - REDIRECT → IDLE on the edge where `redirect_ready_i` = 1.
- `flush_o = busy_o = (state ≠ IDLE)`. `redirect_valid_o = (state == REDIRECT)`.
- Inputs are ignored outside IDLE. `redirect_ready_i` is ignored outside REDIRECT.
- `mem_valid_i = 0` means no exception, including a pending interrupt, which waits for a valid instruction.

## Timing
- Reset values: every output 0, state IDLE, counter 0, synchroniser flops 0.
- `hw_int_i` edge reaches `hw_int_sync_o` after SYNC_STAGES clock edges.
- Detection in cycle N gives:
  - `exc_commit_o` = 1 in cycle N+1 only; `exc_*` data stable from N+1 until the next commit.
  - `flush_o` high from N+1.
  - `redirect_valid_o` high from N+1+FLUSH_CYCLES.
- Once raised, `redirect_valid_o` and `redirect_pc_o` hold until the ready handshake. Ready may already be high on the first REDIRECT cycle; REDIRECT then lasts one cycle.
- The cycle after the handshake is IDLE, and a new exception can be detected in it.
- Asynchronous reset mid-FLUSH or mid-REDIRECT drops to IDLE immediately with all outputs 0. No pending redirect is remembered.

## Configuration
- `EXC_TRAP_EN` defined: `mem_trap_i` participates with code 0x0D at lowest priority.
- `EXC_TRAP_EN` undefined: `mem_trap_i` is ignored and no Tr code is ever produced.

## Test plan
- Syscall at PC 0x8000_1000, not in a delay slot, FLUSH_CYCLES=2, ready tied high → one commit pulse with code 0x08, EPC 0x8000_1000, BD 0. `flush_o` high for 3 cycles, with `redirect_valid_o` high in the third at PC 0xBFC0_0380.
- Fetch AdEL at PC 0x8000_2002, in a delay slot, with overflow also set → code 0x04, EPC 0x8000_1FFE, BD 1, BadVAddr 0x8000_2002.
- `hw_int_i[0]` rises with Status = 0x0000_0401 and Cause.IP2 fed back, RI also present → after the sync delay, code 0x00 wins over RI. Repeat with Status.EXL = 1 → RI (0x0A) is taken instead.
- ERET with `cp0_epc_i` = 0x8000_0040, ready held low for 5 REDIRECT cycles → `redirect_valid_o` and PC 0x8000_0040 stable throughout. A syscall presented during busy produces no second commit.
- Async reset asserted in FLUSH cycle 1 → all outputs 0 immediately. After release, a new Bp exception yields code 0x09 normally.
- Trap alone: with `EXC_TRAP_EN` → code 0x0D. Without it → no commit and `flush_o` stays 0.
